// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI client: host writes land in control registers,
// host reads return control or status values on tx_d/tx_en.
module spi_reg_bank #(
  parameter int unsigned         addrsz  = 7,
  parameter int unsigned         payload = 8,
  parameter int unsigned         nregs   = 16,
  parameter int unsigned         nstat   = 8,
  parameter logic [payload-1:0]  rst_val = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [addrsz-1:0]          reg_addr,
  input  logic                       addr_dv,
  input  logic                       rw_out,
  input  logic [payload-1:0]         rx_d,
  input  logic                       rxdv,
  output logic [payload-1:0]         tx_d,
  output logic                       tx_en,
  output logic [nregs*payload-1:0]   ctrl_q,
  input  logic [nstat*payload-1:0]   status_i,
  output logic                       wr_stb,
  output logic [addrsz-1:0]          wr_addr,
  output logic                       rd_stb,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int unsigned CW = (nregs > 1) ? $clog2(nregs) : 1;
  localparam int unsigned SW = (nstat > 1) ? $clog2(nstat) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_LOAD = 3'd1,
    S_RD_HOLD = 3'd2,
    S_WR_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 addr_dv_q, rxdv_q;
  logic [addrsz-1:0]    addr_q, addr_d;
  logic [payload-1:0]   tx_d_q, tx_d_d;
  logic                 tx_en_q, tx_en_d;
  logic                 rd_stb_q, rd_stb_d;
  logic                 wr_stb_q, wr_stb_d;
  logic [addrsz-1:0]    wr_addr_q, wr_addr_d;
  logic                 err_q, err_d, err_set;
  logic                 ctrl_we;
  logic [payload-1:0]   ctrl_mem_q [nregs];
  logic [payload-1:0]   stat_arr   [nstat];

  logic                 addr_rise, rxdv_rise;
  logic [31:0]          addr_ext;
  logic                 is_ctrl, is_stat;
  logic [payload-1:0]   ctrl_rd, stat_rd;
  logic [SW-1:0]        stat_idx;

  assign addr_rise = addr_dv & ~addr_dv_q;
  assign rxdv_rise = rxdv & ~rxdv_q;

  assign addr_ext = 32'(addr_q);
  assign is_ctrl  = addr_ext < nregs;
  assign is_stat  = !is_ctrl && (addr_ext < nregs + nstat);
  assign stat_idx = SW'(addr_ext - nregs);
  assign ctrl_rd  = ctrl_mem_q[addr_q[CW-1:0]];
  assign stat_rd  = stat_arr[stat_idx];

  for (genvar j = 0; j < nstat; j++) begin : g_stat
    assign stat_arr[j] = status_i[j*payload +: payload];
  end

  for (genvar i = 0; i < nregs; i++) begin : g_ctrl
    assign ctrl_q[i*payload +: payload] = ctrl_mem_q[i];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_d_d    = tx_d_q;
    tx_en_d   = tx_en_q;
    rd_stb_d  = 1'b0;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    err_set   = 1'b0;
    ctrl_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (addr_rise) begin
          addr_d  = reg_addr;
          state_d = rw_out ? S_RD_LOAD : S_WR_WAIT;
        end
      end
      S_RD_LOAD: begin
        tx_en_d = 1'b1;
        state_d = S_RD_HOLD;
        if (is_ctrl) begin
          tx_d_d   = ctrl_rd;
          rd_stb_d = 1'b1;
        end else if (is_stat) begin
          tx_d_d   = stat_rd;
          rd_stb_d = 1'b1;
        end else begin
          tx_d_d  = '0;
          err_set = 1'b1;
        end
      end
      S_RD_HOLD: begin
        if (!addr_dv) begin
          tx_en_d = 1'b0;
          tx_d_d  = '0;
          state_d = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (rxdv_rise) begin
          state_d = S_DONE;
          if (is_ctrl) begin
            ctrl_we   = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
          end else begin
            err_set = 1'b1;
          end
        end else if (!addr_dv) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!addr_dv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a new error in the same cycle as err_clr must survive
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_dv_q <= 1'b0;
      rxdv_q    <= 1'b0;
      addr_q    <= '0;
      tx_d_q    <= '0;
      tx_en_q   <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_dv_q <= addr_dv;
      rxdv_q    <= rxdv;
      addr_q    <= addr_d;
      tx_d_q    <= tx_d_d;
      tx_en_q   <= tx_en_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < nregs; i++) ctrl_mem_q[i] <= rst_val;
    end else if (ctrl_we) begin
      ctrl_mem_q[addr_q[CW-1:0]] <= rx_d;
    end
  end

  assign tx_d    = tx_d_q;
  assign tx_en   = tx_en_q;
  assign rd_stb  = rd_stb_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign err     = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: writes, read-back, status protection,
// unmapped access, aborted write and reset in the middle of a read.
module tb_spi_reg_bank;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [6:0]   reg_addr = '0;
  logic         addr_dv = 1'b0;
  logic         rw_out = 1'b0;
  logic [7:0]   rx_d = '0;
  logic         rxdv = 1'b0;
  logic [7:0]   tx_d;
  logic         tx_en;
  logic [127:0] ctrl_q;
  logic [63:0]  status_i = 64'h07_06_05_04_03_5C_01_00;
  logic         wr_stb;
  logic [6:0]   wr_addr;
  logic         rd_stb;
  logic         err;
  logic         err_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int cnt0;
  logic [127:0] exp_ctrl = '0;

  spi_reg_bank dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .reg_addr (reg_addr),
    .addr_dv  (addr_dv),
    .rw_out   (rw_out),
    .rx_d     (rx_d),
    .rxdv     (rxdv),
    .tx_d     (tx_d),
    .tx_en    (tx_en),
    .ctrl_q   (ctrl_q),
    .status_i (status_i),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .rd_stb   (rd_stb),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) wr_cnt++;
    if (rd_stb) rd_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d,
                          input logic exp_stb, input logic exp_err);
    @(negedge clk);
    reg_addr = a; rw_out = 1'b0; addr_dv = 1'b1;
    repeat (3) @(negedge clk);
    rx_d = d; rxdv = 1'b1;
    @(posedge clk); #1;
    check("wr_stb_pulse", wr_stb, exp_stb);
    check("wr_err", err, exp_err);
    @(posedge clk); #1;
    check("wr_stb_single", wr_stb, 1'b0);
    @(negedge clk);
    addr_dv = 1'b0; rxdv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read(input logic [6:0] a, input logic [7:0] exp_d,
                         input logic exp_stb, input logic exp_err);
    @(negedge clk);
    reg_addr = a; rw_out = 1'b1; addr_dv = 1'b1;
    @(posedge clk); #1;
    check("rd_load_tx_en", tx_en, 1'b0);
    @(posedge clk); #1;
    check("rd_tx_d", tx_d, exp_d);
    check("rd_tx_en", tx_en, 1'b1);
    check("rd_stb", rd_stb, exp_stb);
    check("rd_err", err, exp_err);
    @(posedge clk); #1;
    check("rd_stb_single", rd_stb, 1'b0);
    check("rd_tx_d_hold", tx_d, exp_d);
    check("rd_tx_en_hold", tx_en, 1'b1);
    @(negedge clk);
    addr_dv = 1'b0;
    @(posedge clk); #1;
    check("rd_tx_en_fall", tx_en, 1'b0);
    check("rd_tx_d_clear", tx_d, 8'h00);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_d", tx_d, 8'h00);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_ctrl", ctrl_q, 128'h0);
    check("rst_wr_addr", wr_addr, 7'h00);
    check("rst_err", err, 1'b0);
    check("rst_stbs", {wr_stb, rd_stb}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    cnt0 = wr_cnt;
    do_write(7'h03, 8'hA5, 1'b1, 1'b0);
    exp_ctrl[3*8 +: 8] = 8'hA5;
    check("w3_ctrl", ctrl_q, exp_ctrl);
    check("w3_ctrl_byte", ctrl_q[31:24], 8'hA5);
    check("w3_wr_cnt", wr_cnt - cnt0, 1);
    check("w3_wr_addr", wr_addr, 7'h03);

    cnt0 = rd_cnt;
    do_read(7'h03, 8'hA5, 1'b1, 1'b0);
    check("r3_rd_cnt", rd_cnt - cnt0, 1);

    do_write(7'h0F, 8'h3C, 1'b1, 1'b0);
    exp_ctrl[15*8 +: 8] = 8'h3C;
    check("w15_ctrl", ctrl_q, exp_ctrl);
    check("w15_wr_addr", wr_addr, 7'h0F);
    do_read(7'h0F, 8'h3C, 1'b1, 1'b0);

    do_read(7'd18, 8'h5C, 1'b1, 1'b0);
    do_read(7'd16, 8'h00, 1'b1, 1'b0);
    do_read(7'd23, 8'h07, 1'b1, 1'b0);

    cnt0 = wr_cnt;
    do_write(7'd18, 8'hFF, 1'b0, 1'b1);
    check("wstat_ctrl", ctrl_q, exp_ctrl);
    check("wstat_wr_cnt", wr_cnt - cnt0, 0);
    check("wstat_wr_addr", wr_addr, 7'h0F);
    check("wstat_err_sticky", err, 1'b1);

    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    check("err_clr", err, 1'b0);
    @(negedge clk);
    err_clr = 1'b0;

    cnt0 = rd_cnt;
    do_read(7'h7F, 8'h00, 1'b0, 1'b1);
    check("unmapped_rd_cnt", rd_cnt - cnt0, 0);
    check("unmapped_err_sticky", err, 1'b1);

    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    check("err_clr2", err, 1'b0);
    // err_clr held through a fresh unmapped read: the set must win
    do_read(7'h7F, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    err_clr = 1'b0;
    @(posedge clk); #1;
    check("err_after_clr_hold", err, 1'b0);

    cnt0 = wr_cnt;
    @(negedge clk);
    reg_addr = 7'h05; rw_out = 1'b0; addr_dv = 1'b1;
    repeat (3) @(negedge clk);
    addr_dv = 1'b0;
    repeat (3) @(negedge clk);
    rx_d = 8'h77; rxdv = 1'b1;
    repeat (2) @(negedge clk);
    rxdv = 1'b0;
    #1;
    check("abort_ctrl", ctrl_q, exp_ctrl);
    check("abort_wr_cnt", wr_cnt - cnt0, 0);
    check("abort_err", err, 1'b0);
    do_read(7'h05, 8'h00, 1'b1, 1'b0);

    @(negedge clk);
    reg_addr = 7'h03; rw_out = 1'b1; addr_dv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_tx_en", tx_en, 1'b1);
    check("hold_tx_d", tx_d, 8'hA5);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_tx_en", tx_en, 1'b0);
    check("midrst_tx_d", tx_d, 8'h00);
    check("midrst_ctrl", ctrl_q, 128'h0);
    check("midrst_wr_addr", wr_addr, 7'h00);
    check("midrst_err", err, 1'b0);
    addr_dv = 1'b0;
    exp_ctrl = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_read(7'h03, 8'h00, 1'b1, 1'b0);
    do_write(7'h03, 8'h11, 1'b1, 1'b0);
    exp_ctrl[3*8 +: 8] = 8'h11;
    check("post_rst_ctrl", ctrl_q, exp_ctrl);
    check("post_rst_wr_addr", wr_addr, 7'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
